// File: rtl/gactx_axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : gactx_axi_mem_responder
// Description : AXI4 INCR burst slave backed by beat-wide byte-strobed memory.
// Revision    : 1.0 - initial release
// ============================================================================
module gactx_axi_mem_responder #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 1024,
  parameter int C_MEM_DEPTH_WORDS  = 256
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            err_wlast
);

  localparam int c_bytes    = C_S_AXI_DATA_WIDTH / 8;
  localparam int c_off_bits = $clog2(c_bytes);
  localparam int c_idx_bits = $clog2(C_MEM_DEPTH_WORDS);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [C_MEM_DEPTH_WORDS];

  wstate_t                 r_wstate;
  wstate_t                 w_wstate_nxt;
  logic [c_idx_bits-1:0]   r_widx;
  logic [7:0]              r_awlen;
  logic [7:0]              r_wcnt;
  logic                    r_err_wlast;
  logic                    w_aw_fire;
  logic                    w_w_fire;
  logic                    w_w_final;

  rstate_t                 r_rstate;
  rstate_t                 w_rstate_nxt;
  logic [c_idx_bits-1:0]   r_ridx;
  logic [7:0]              r_arlen;
  logic [7:0]              r_rcnt;
  logic [7:0]              w_rcnt_inc;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic                    r_rlast;
  logic                    w_ar_fire;
  logic                    w_r_fire;
  logic [c_idx_bits-1:0]   w_aw_idx;
  logic [c_idx_bits-1:0]   w_ar_idx;

  // Byte-offset and above-depth address bits are deliberately discarded.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  assign w_aw_idx = s_axi_awaddr[c_off_bits +: c_idx_bits];
  assign w_ar_idx = s_axi_araddr[c_off_bits +: c_idx_bits];

  // ---------------------------------------------------------------- write
  assign s_axi_awready = (r_wstate == W_IDLE) && !areset;
  assign s_axi_wready  = (r_wstate == W_DATA);
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign err_wlast     = r_err_wlast;

  assign w_aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_w_fire  = s_axi_wvalid && s_axi_wready;
  assign w_w_final = (r_wcnt == r_awlen);

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_fire) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_fire && w_w_final) w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axi_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_widx      <= '0;
      r_awlen     <= '0;
      r_wcnt      <= '0;
      r_err_wlast <= 1'b0;
    end else begin
      if (w_aw_fire) begin
        r_widx  <= w_aw_idx;
        r_awlen <= s_axi_awlen;
        r_wcnt  <= '0;
      end else if (w_w_fire) begin
        r_widx <= r_widx + 1'b1;
        r_wcnt <= r_wcnt + 8'd1;
        // Burst length follows awlen; wlast is only checked for consistency.
        if (s_axi_wlast != w_w_final) r_err_wlast <= 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_w_fire) begin
      for (int b = 0; b < c_bytes; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  assign s_axi_arready = (r_rstate == R_IDLE) && !areset;
  assign s_axi_rvalid  = (r_rstate == R_DATA);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rlast   = r_rlast;

  assign w_ar_fire  = s_axi_arvalid && s_axi_arready;
  assign w_r_fire   = s_axi_rvalid && s_axi_rready;
  assign w_rcnt_inc = r_rcnt + 8'd1;

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_fire) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_fire && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // r_ridx always points at the word to present on the next accepted beat.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_ridx  <= '0;
      r_arlen <= '0;
      r_rcnt  <= '0;
      r_rdata <= '0;
      r_rlast <= 1'b0;
    end else begin
      if (w_ar_fire) begin
        r_rdata <= r_mem[w_ar_idx];
        r_ridx  <= w_ar_idx + 1'b1;
        r_arlen <= s_axi_arlen;
        r_rcnt  <= '0;
        r_rlast <= (s_axi_arlen == 8'd0);
      end else if (w_r_fire) begin
        if (r_rlast) begin
          r_rlast <= 1'b0;
        end else begin
          r_rdata <= r_mem[r_ridx];
          r_ridx  <= r_ridx + 1'b1;
          r_rcnt  <= w_rcnt_inc;
          r_rlast <= (w_rcnt_inc == r_arlen);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gactx_axi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gactx_axi_mem_responder
// Description : Directed self-checking bench for gactx_axi_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gactx_axi_mem_responder;
  localparam int AW = 64;
  localparam int DW = 1024;
  localparam int SW = DW / 8;

  logic          ap_clk = 1'b0;
  logic          areset = 1'b1;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic [7:0]    s_axi_awlen = '0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [SW-1:0] s_axi_wstrb = '0;
  logic          s_axi_wlast = 1'b0;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic          s_axi_arvalid = 1'b0;
  logic          s_axi_arready;
  logic [AW-1:0] s_axi_araddr = '0;
  logic [7:0]    s_axi_arlen = '0;
  logic          s_axi_rvalid;
  logic          s_axi_rready = 1'b0;
  logic [DW-1:0] s_axi_rdata;
  logic          s_axi_rlast;
  logic          err_wlast;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] wbuf [4];
  logic [DW-1:0] ebuf [4];
  logic [DW-1:0] val_a;
  logic [DW-1:0] val_b;
  int            beat;
  logic [5:0]    rpat;

  gactx_axi_mem_responder dut (
    .ap_clk        (ap_clk),
    .areset        (areset),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rlast   (s_axi_rlast),
    .err_wlast     (err_wlast)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed[255:0] %h expected[255:0] %h", tag, obs[255:0], exp[255:0]);
    end
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [SW-1:0] strb, input int early_last);
    int waits;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awvalid = 1'b1;
    waits = 0;
    while (!s_axi_awready && waits < 50) begin tick(); waits++; end
    chk1("awready_wait", s_axi_awready, 1'b1);
    tick();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata  = wbuf[i];
      s_axi_wstrb  = strb;
      s_axi_wlast  = (i == int'(len)) || (i == early_last);
      s_axi_wvalid = 1'b1;
      waits = 0;
      while (!s_axi_wready && waits < 50) begin tick(); waits++; end
      chk1("wready_wait", s_axi_wready, 1'b1);
      chk1("bvalid_before_last", s_axi_bvalid, 1'b0);
      tick();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    chk1("bvalid_after_last", s_axi_bvalid, 1'b1);
    chk1("wready_in_resp", s_axi_wready, 1'b0);
    tick();
    chk1("bvalid_held", s_axi_bvalid, 1'b1);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk1("bvalid_cleared", s_axi_bvalid, 1'b0);
    chk1("awready_back", s_axi_awready, 1'b1);
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input logic [7:0] len);
    int waits;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arvalid = 1'b1;
    waits = 0;
    while (!s_axi_arready && waits < 50) begin tick(); waits++; end
    chk1("arready_wait", s_axi_arready, 1'b1);
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      chk1("rvalid_beat", s_axi_rvalid, 1'b1);
      chkd("rdata_beat", s_axi_rdata, ebuf[i]);
      chk1("rlast_beat", s_axi_rlast, i == int'(len));
      tick();
    end
    s_axi_rready = 1'b0;
    chk1("rvalid_after_burst", s_axi_rvalid, 1'b0);
    chk1("rlast_after_burst", s_axi_rlast, 1'b0);
    chk1("arready_after_burst", s_axi_arready, 1'b1);
  endtask

  initial begin
    // Reset state
    #1;
    chk1("rst_awready", s_axi_awready, 1'b0);
    chk1("rst_arready", s_axi_arready, 1'b0);
    chk1("rst_wready", s_axi_wready, 1'b0);
    chk1("rst_bvalid", s_axi_bvalid, 1'b0);
    chk1("rst_rvalid", s_axi_rvalid, 1'b0);
    chk1("rst_rlast", s_axi_rlast, 1'b0);
    chk1("rst_err", err_wlast, 1'b0);
    chkd("rst_rdata", s_axi_rdata, '0);
    tick();
    tick();
    areset = 1'b0;
    tick();
    chk1("post_rst_awready", s_axi_awready, 1'b1);
    chk1("post_rst_arready", s_axi_arready, 1'b1);

    // Burst round-trip 1,2,3,4
    for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
    write_burst(64'd0, 8'd3, '1, -1);
    chk1("rt_err", err_wlast, 1'b0);
    for (int i = 0; i < 4; i++) ebuf[i] = DW'(i + 1);
    read_burst(64'd0, 8'd3);

    // Byte strobes on word 5
    wbuf[0] = '1;
    write_burst(64'd640, 8'd0, '1, -1);
    wbuf[0] = {SW{8'hAB}};
    write_burst(64'd640, 8'd0, SW'(1), -1);
    ebuf[0] = {{(SW-1){8'hFF}}, 8'hAB};
    read_burst(64'd640, 8'd0);

    // Wrap past the top of memory
    val_a = {32{32'hA5A5_0001}};
    val_b = {32{32'h5A5A_0002}};
    wbuf[0] = val_a;
    wbuf[1] = val_b;
    write_burst(64'd32640, 8'd1, '1, -1);
    ebuf[0] = val_a;
    ebuf[1] = val_b;
    read_burst(64'd32640, 8'd1);
    ebuf[0] = val_b;
    read_burst(64'd0, 8'd0);
    // Upper address bits alias onto word 255
    ebuf[0] = val_a;
    read_burst(64'h1_0000_7F80, 8'd0);

    // Read backpressure, rready 1,0,0,1,1,1; word 0 now holds B
    ebuf[0] = val_b;
    ebuf[1] = DW'(2);
    ebuf[2] = DW'(3);
    ebuf[3] = DW'(4);
    rpat = 6'b111001;
    s_axi_araddr  = 64'd0;
    s_axi_arlen   = 8'd3;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    beat = 0;
    for (int c = 0; c < 6; c++) begin
      s_axi_rready = rpat[c];
      chk1("bp_rvalid", s_axi_rvalid, 1'b1);
      chkd("bp_rdata", s_axi_rdata, ebuf[beat]);
      chk1("bp_rlast", s_axi_rlast, beat == 3);
      if (rpat[c]) beat++;
      tick();
    end
    s_axi_rready = 1'b0;
    chk1("bp_done_rvalid", s_axi_rvalid, 1'b0);
    chk1("bp_done_arready", s_axi_arready, 1'b1);

    // wlast asserted early on the first beat of a 4-beat burst
    for (int i = 0; i < 4; i++) wbuf[i] = DW'(10 + i);
    write_burst(64'd1280, 8'd3, '1, 0);
    chk1("wlast_err_set", err_wlast, 1'b1);
    for (int i = 0; i < 4; i++) ebuf[i] = DW'(10 + i);
    read_burst(64'd1280, 8'd3);
    chk1("wlast_err_sticky", err_wlast, 1'b1);

    // Reset during read beat 2
    ebuf[0] = val_b;
    s_axi_araddr  = 64'd0;
    s_axi_arlen   = 8'd3;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    chkd("mr_beat1", s_axi_rdata, val_b);
    tick();
    chkd("mr_beat2", s_axi_rdata, DW'(2));
    chk1("mr_beat2_valid", s_axi_rvalid, 1'b1);
    areset = 1'b1;
    #1;
    chk1("mr_rvalid_async", s_axi_rvalid, 1'b0);
    chk1("mr_rlast_async", s_axi_rlast, 1'b0);
    chkd("mr_rdata_async", s_axi_rdata, '0);
    chk1("mr_err_cleared", err_wlast, 1'b0);
    chk1("mr_arready_low", s_axi_arready, 1'b0);
    s_axi_rready = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    tick();
    chk1("mr_arready_after", s_axi_arready, 1'b1);
    ebuf[0] = val_b;
    ebuf[1] = DW'(2);
    ebuf[2] = DW'(3);
    ebuf[3] = DW'(4);
    read_burst(64'd0, 8'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
